// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle. Divide-by-zero and signed overflow bypass straight to DONE.
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_start,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_dividend,
   input  logic [XLEN-1:0] i_divisor,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   // state  | meaning
   // S_IDLE | waiting for start, result held
   // S_CALC | one restoring step per cycle, r_cnt counts down to 0
   // S_DONE | one-cycle done pulse, may accept a new start
   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [5:0]      r_cnt;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quot;
   logic [XLEN-1:0] r_dvs_mag;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_op_rem;
   logic            r_done;
   logic [XLEN-1:0] r_result;

   logic            w_accept;
   logic            w_signed;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_special_res;
   logic            w_dvd_neg;
   logic            w_dvs_neg;
   logic [XLEN-1:0] w_dvd_mag;
   logic [XLEN-1:0] w_dvs_mag;
   logic [XLEN:0]   w_shift;
   logic [XLEN+1:0] w_trial;
   logic            w_q_bit;
   logic [XLEN-1:0] w_rem_nxt;
   logic [XLEN-1:0] w_quot_nxt;
   logic [XLEN-1:0] w_final;

   assign w_accept   = i_start & (r_state != S_CALC);
   assign w_signed   = ~i_op[0];
   assign w_div_zero = (i_divisor == '0);
   assign w_ovf      = w_signed & (i_dividend == {1'b1, {(XLEN-1){1'b0}}})
                       & (i_divisor == {XLEN{1'b1}});
   assign w_special  = w_div_zero | w_ovf;

   always_comb begin
      w_special_res = '0;
      if (w_div_zero)
         w_special_res = i_op[1] ? i_dividend : {XLEN{1'b1}};
      else if (w_ovf)
         w_special_res = i_op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   assign w_dvd_neg = w_signed & i_dividend[XLEN-1];
   assign w_dvs_neg = w_signed & i_divisor[XLEN-1];
   assign w_dvd_mag = w_dvd_neg ? -i_dividend : i_dividend;
   assign w_dvs_mag = w_dvs_neg ? -i_divisor : i_divisor;

   // The shifted remainder can reach 2*divisor-1, so the trial needs a spare bit plus a sign bit.
   assign w_shift    = {r_rem, r_quot[XLEN-1]};
   assign w_trial    = {1'b0, w_shift} - {2'b00, r_dvs_mag};
   assign w_q_bit    = ~w_trial[XLEN+1];
   assign w_rem_nxt  = w_q_bit ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
   assign w_quot_nxt = {r_quot[XLEN-2:0], w_q_bit};
   assign w_final    = r_op_rem ? (r_neg_r ? -w_rem_nxt : w_rem_nxt)
                                : (r_neg_q ? -w_quot_nxt : w_quot_nxt);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
         S_CALC: if (r_cnt == '0) w_state_nxt = S_DONE;
         S_DONE: begin
            if (w_accept) w_state_nxt = w_special ? S_DONE : S_CALC;
            else          w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quot    <= '0;
         r_dvs_mag <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_op_rem  <= 1'b0;
         r_done    <= 1'b0;
         r_result  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= (w_state_nxt == S_DONE);
         if (w_accept) begin
            r_op_rem  <= i_op[1];
            r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r   <= w_dvd_neg;
            r_rem     <= '0;
            r_quot    <= w_dvd_mag;
            r_dvs_mag <= w_dvs_mag;
            r_cnt     <= 6'(XLEN - 1);
            if (w_special) r_result <= w_special_res;
         end else if (r_state == S_CALC) begin
            r_rem  <= w_rem_nxt;
            r_quot <= w_quot_nxt;
            r_cnt  <= r_cnt - 6'd1;
            if (r_cnt == '0) r_result <= w_final;
         end
      end
   end

   assign o_busy   = (r_state == S_CALC) | w_accept;
   assign o_done   = r_done;
   assign o_result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, busy window, special cases,
// reset abort and back-to-back starts, against hand-computed results.
module tb_div_unit;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] dividend;
   logic [31:0] divisor;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

   div_unit #(.XLEN(32)) dut (
      .i_clk      (clk_sys),
      .i_reset_n  (reset_n),
      .i_start    (start),
      .i_op       (op),
      .i_dividend (dividend),
      .i_divisor  (divisor),
      .o_busy     (busy),
      .o_done     (done),
      .o_result   (result)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Drive a request in the current cycle (caller is just past a rising edge).
   task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start    = 1'b1;
      op       = o;
      dividend = a;
      divisor  = b;
   endtask

   // Walk cycles after a launch; return sampled in the done cycle.
   task automatic follow(input int lat, input logic [31:0] exp, input string tag);
      int done_cyc = -1;
      int busy_hi  = 0;
      for (int c = 1; c <= lat + 4 && done_cyc < 0; c++) begin
         @(posedge clk_sys);
         #1;
         if (c == 1) begin
            start    = 1'b0;
            op       = 2'($urandom);
            dividend = $urandom;
            divisor  = $urandom;
         end
         #2;
         if (done) done_cyc = c;
         else if (busy) busy_hi++;
      end
      chk({tag, " latency"}, done_cyc, lat);
      chk({tag, " result"}, result, exp);
      chk({tag, " busy cycles"}, busy_hi, lat - 1);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string tag);
      @(posedge clk_sys);
      #1;
      launch(o, a, b);
      #2;
      chk({tag, " busy c0"}, busy, 1);
      follow(lat, exp, tag);
   endtask

   initial begin
      int done_cnt;
      reset_n  = 1'b0;
      start    = 1'b0;
      op       = 2'b00;
      dividend = '0;
      divisor  = '0;
      repeat (3) @(posedge clk_sys);
      #3;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result, 0);
      @(posedge clk_sys);
      #1;
      reset_n = 1'b1;
      #2;
      chk("idle busy", busy, 0);

      run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu 100/7");
      repeat (7) @(posedge clk_sys);
      #3;
      chk("divu 100/7 held c40", result, 32'd14);
      chk("idle busy after done", busy, 0);

      run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem -7/2");
      run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div -7/2");
      run_op(OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1,         33, "remu fff9/2");

      run_op(OP_DIV,  32'd1234, 32'd0, 32'hFFFF_FFFF, 1, "div by zero");
      run_op(OP_REMU, 32'd1234, 32'd0, 32'd1234,      1, "remu by zero");

      run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div ovf");
      run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem ovf");
      run_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33, "divu 8000/ffff");
      run_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "remu 8000/ffff");

      // Reset abort: launch in cycle 0, reset sampled at the end of cycle 10.
      @(posedge clk_sys);
      #1;
      launch(OP_DIVU, 32'd1000, 32'd3);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk_sys);
         #1;
         if (c == 1) start = 1'b0;
      end
      reset_n = 1'b0;
      @(posedge clk_sys);
      #1;
      reset_n = 1'b1;
      #2;
      chk("abort busy", busy, 0);
      chk("abort result", result, 0);
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk_sys);
         #3;
         if (done) done_cnt++;
      end
      chk("abort no done", done_cnt, 0);
      chk("abort busy later", busy, 0);
      run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu 9/3 after reset");

      // Back-to-back: new start issued in the DONE cycle of the first op.
      @(posedge clk_sys);
      #1;
      launch(OP_DIVU, 32'd50, 32'd5);
      follow(33, 32'd10, "b2b first");
      launch(OP_DIV, 32'hFFFF_FF9C, 32'd10);
      #1;
      chk("b2b done in start cycle", done, 1);
      chk("b2b busy in start cycle", busy, 1);
      chk("b2b old result", result, 32'd10);
      follow(33, 32'hFFFF_FFF6, "b2b second");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
